// File: rtl/resp_gen_2.sv
// Responder side of the round-2 key confirmation: captures the initiator nonce,
// waits for the shared key, returns c_2 = r_1 ^ k with a done strobe held DONE_HOLD cycles.
module resp_gen_2 #(
  parameter int WIDTH       = 64,
  parameter int TIMEOUT_CYC = 255,
  parameter int DONE_HOLD   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r_1_i,
  input  logic             r_1_valid_i,
  output logic             r_1_ready_o,
  input  logic [WIDTH-1:0] k_i,
  input  logic             key_valid_i,
  output logic [WIDTH-1:0] c_2_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(DONE_HOLD - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   nonce_q, nonce_d;
  logic [WIDTH-1:0]   c2_q, c2_d;
  logic               done_q, done_d;
  logic               to_q, to_d;
  logic [15:0]        wcnt_q, wcnt_d;
  logic [15:0]        hcnt_q, hcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      nonce_q <= '0;
      c2_q    <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      c2_q    <= c2_d;
      done_q  <= done_d;
      to_q    <= to_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    c2_d    = c2_q;
    done_d  = done_q;
    to_d    = 1'b0;
    wcnt_d  = wcnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (r_1_valid_i) begin
          nonce_d = r_1_i;
          wcnt_d  = '0;
          state_d = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        // key takes priority over an expiring wait counter
        if (key_valid_i) begin
          c2_d    = nonce_q ^ k_i;
          done_d  = 1'b1;
          hcnt_d  = '0;
          state_d = RESP;
        end else if (wcnt_q == WAIT_LAST) begin
          to_d    = 1'b1;
          nonce_d = '0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      RESP: begin
        if (hcnt_q == HOLD_LAST) begin
          done_d  = 1'b0;
          c2_d    = '0;
          nonce_d = '0;
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign r_1_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign c_2_o       = c2_q;
  assign done_o      = done_q;
  assign timeout_o   = to_q;

endmodule
